div_unit: RTL

- Multi-cycle radix-2 restoring divider in the EX stage. Executes DIV and DIVU.
- Initiates pipeline stalls: raises stall_request, which the pipeline stall controller takes as its EX stall input, for the full duration of a divide.
- Returns {remainder, quotient} for the HI/LO write.

---
 rtl/div_unit_pkg.sv | 20 ++
 rtl/div_unit_div_step.sv | 34 +++
 rtl/div_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared defines for the EX-stage divider: FSM state encodings, the default
// operand width and the reset/stall enable levels used across the pipeline.
package div_unit_pkg;

  // Divider FSM states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  // Default operand width; results are twice this wide
  localparam int DIV_WIDTH = 32;

  // Active levels shared with the rest of the pipeline
  localparam logic RESET_ENABLE = 1'b1;
  localparam logic STALL_ENABLE = 1'b1;

endpackage

// File: rtl/div_unit_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// Shifts {rem, quo} left by one, trial-subtracts the divisor from the upper
// WIDTH+1 bits and keeps the difference when it is non-negative.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  // Shift, trial subtract, restore or keep. rem < divisor on entry, so the
  // difference is always below 2^WIDTH when non-negative and bit WIDTH acts
  // as the borrow.
  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    diff      = rem_shift - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV / DIVU in the EX stage.
// Raises stall_request for the whole operation and returns
// {remainder, quotient} for the HI/LO write.
// Optional build macro DIV_ZERO_FLAG_EN adds a registered div_by_zero output.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               annul,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
`ifdef DIV_ZERO_FLAG_EN
  output logic               div_by_zero,
`endif
  output logic               stall_request
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

  div_state_t state_reg, state_next;

  logic [WIDTH-1:0]   rem_reg, quo_reg, dvs_reg;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic [WIDTH-1:0]   rem_final, quo_final;
  logic [WIDTH-1:0]   dividend_abs, divisor_abs;
  logic [CNT_W-1:0]   count_reg;
  logic               sign_a_reg, sign_b_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               ready_reg;
  logic               zero_flag_reg;
  logic               accept, cancel;

  assign accept = start && !annul;
  assign cancel = annul || !start;

  assign result = result_reg;
  assign ready  = ready_reg;
`ifdef DIV_ZERO_FLAG_EN
  assign div_by_zero = zero_flag_reg;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (dvs_reg),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Operand magnitudes; the unsigned path uses the raw full-width values
  always_comb begin
    dividend_abs = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_abs  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // Sign correction applied on the finalise edge
  always_comb begin
    quo_final = (sign_a_reg ^ sign_b_reg) ? -quo_reg : quo_reg;
    rem_final = sign_a_reg ? -rem_reg : rem_reg;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) state_reg <= DIV_IDLE;
    else                       state_reg <= state_next;
  end

  // Next-state logic; a cancel takes priority over finishing
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DIV_IDLE: if (accept) state_next = (divisor == '0) ? DIV_ZERO : DIV_BUSY;
      DIV_BUSY: begin
        if (cancel)                       state_next = DIV_IDLE;
        else if (count_reg == LAST_STEP)  state_next = DIV_DONE;
      end
      DIV_ZERO: state_next = cancel ? DIV_IDLE : DIV_DONE;
      DIV_DONE: if (!start) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Stall the pipeline while a divide is requested and not yet complete
  always_comb begin
    stall_request = 1'b0;
    if (start && !annul && (state_reg != DIV_DONE) && (reset != RESET_ENABLE))
      stall_request = STALL_ENABLE;
  end

  // Datapath: operand latch, iteration, finalise and result hold
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      count_reg     <= '0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      result_reg    <= '0;
      ready_reg     <= 1'b0;
      zero_flag_reg <= 1'b0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (accept && (divisor != '0)) begin
            rem_reg    <= '0;
            quo_reg    <= dividend_abs;
            dvs_reg    <= divisor_abs;
            count_reg  <= '0;
            sign_a_reg <= signed_div & dividend[WIDTH-1];
            sign_b_reg <= signed_div & divisor[WIDTH-1];
          end
        end
        DIV_BUSY: begin
          if (!cancel) begin
            if (count_reg == LAST_STEP) begin
              result_reg    <= {rem_final, quo_final};
              ready_reg     <= 1'b1;
              zero_flag_reg <= 1'b0;
            end else begin
              rem_reg   <= rem_step;
              quo_reg   <= quo_step;
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        DIV_ZERO: begin
          if (!cancel) begin
            result_reg    <= '0;
            ready_reg     <= 1'b1;
            zero_flag_reg <= 1'b1;
          end
        end
        DIV_DONE: begin
          if (!start) begin
            ready_reg     <= 1'b0;
            zero_flag_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef DIV_ZERO_FLAG_EN
  // Flag register is only observable when the optional output exists
  logic unused_flag;
  assign unused_flag = zero_flag_reg;
`endif

endmodule
